// File: rtl/if_prefetch_if.sv
// Fetch-stage bus: instruction-memory request/response channel plus the
// decode-side queue head and branch-redirect inputs.
interface if_prefetch_if #(
    parameter int unsigned AW = 32
);
    logic          im_req;
    logic [AW-1:0] im_addr;
    logic          im_gnt;
    logic          im_rvalid;
    logic [31:0]   im_rdata;
    logic          id_valid;
    logic [31:0]   id_instr;
    logic [AW-1:0] id_pc4;
    logic          id_ready;
    logic          redir;
    logic [AW-1:0] redir_pc;
    logic [AW-1:0] fetch_pc;

    // Fetch stage side
    modport master (
        output im_req, im_addr, id_valid, id_instr, id_pc4, fetch_pc,
        input  im_gnt, im_rvalid, im_rdata, id_ready, redir, redir_pc
    );

    // Memory / decode side
    modport slave (
        input  im_req, im_addr, id_valid, id_instr, id_pc4, fetch_pc,
        output im_gnt, im_rvalid, im_rdata, id_ready, redir, redir_pc
    );
endinterface

// File: rtl/if_prefetch.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue of {pc4, instr}.
// Requests are credit-limited so queued plus in-flight never exceeds DEPTH;
// a redirect flushes the queue and marks every in-flight response for drop.
module if_prefetch #(
    parameter int unsigned   AW       = 32,
    parameter int unsigned   DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           rst,
    if_prefetch_if.master bus
);
    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam logic [AW-1:0] PC_STEP = AW'(4);

    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] expect_pc_q, expect_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [AW-1:0] pc4_mem_q   [DEPTH];

    logic          grant;
    logic          rsp;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_used;
    logic [AW-1:0] redir_target;

    assign credit_used  = {1'b0, count_q} + {1'b0, outst_q};
    assign redir_target = {bus.redir_pc[AW-1:2], 2'b00};

    // Reset gates the request combinationally so it drops the moment rst rises.
    assign bus.im_req   = !rst && !bus.redir && (credit_used < (CW + 1)'(DEPTH));
    assign bus.im_addr  = fetch_pc_q;
    assign bus.fetch_pc = fetch_pc_q;
    assign bus.id_valid = (count_q != '0);
    assign bus.id_instr = instr_mem_q[rd_ptr_q];
    assign bus.id_pc4   = pc4_mem_q[rd_ptr_q];

    assign grant = bus.im_req && bus.im_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp   = bus.im_rvalid && (outst_q != '0);
    assign push  = rsp && (drop_q == '0) && !bus.redir;
    assign pop   = (count_q != '0) && bus.id_ready && !bus.redir;

    // Next-state: redirect overrides every other update in its cycle.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        expect_pc_d = expect_pc_q;
        count_d     = count_q;
        outst_d     = outst_q;
        drop_d      = drop_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (bus.redir) begin
            fetch_pc_d  = redir_target;
            expect_pc_d = redir_target;
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            // Everything still in flight after this edge belongs to the old path.
            outst_d     = outst_q - CW'(rsp);
            drop_d      = outst_q - CW'(rsp);
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (push) begin
                expect_pc_d = expect_pc_q + PC_STEP;
                wr_ptr_d    = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            outst_d = outst_q + CW'(grant) - CW'(rsp);
            if (rsp && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            expect_pc_q <= RESET_PC;
            count_q     <= '0;
            outst_q     <= '0;
            drop_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            expect_pc_q <= expect_pc_d;
            count_q     <= count_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Queue storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_q[i] <= '0;
                pc4_mem_q[i]   <= '0;
            end
        end else if (push) begin
            instr_mem_q[wr_ptr_q] <= bus.im_rdata;
            pc4_mem_q[wr_ptr_q]   <= expect_pc_q + PC_STEP;
        end
    end
endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: table-driven startup vectors, hand-written corner
// sequences and a randomized run, all checked against a stream-level model
// (expected PC stream, queue of accepted words, memory with tagged epochs).
module tb_if_prefetch;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_prefetch_if #(.AW(32)) bus ();
    if_prefetch_if #(.AW(8))  bus8 ();

    if_prefetch #(.AW(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    if_prefetch #(.AW(8), .DEPTH(DEPTH), .RESET_PC(8'h0)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned rdy;
    } req_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    typedef struct {
        logic        gnt;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc4;
    } vec_t;

    req_t        mq[$];
    ent_t        qm[$];
    int unsigned epoch;
    int unsigned cyc;
    logic [31:0] fetch_exp;
    int          n_chk;
    int          n_fail;
    int          n_consumed;

    logic        c_gnt, c_ready, c_redir, c_redir8;
    logic [31:0] c_rpc;
    logic [7:0]  c_rpc8;
    int unsigned c_lat;
    logic        nxt8;
    logic        cur_rv;
    logic [31:0] cur_rdata;

    logic        s_req, s_valid, s8_req, s8_valid;
    logic [31:0] s_addr, s_pc4, s_instr;
    logic [7:0]  s8_addr, s8_pc4;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        c_gnt = 1'b0; c_ready = 1'b0; c_redir = 1'b0; c_rpc = '0; c_lat = 1;
        c_redir8 = 1'b0; c_rpc8 = '0; nxt8 = 1'b0;
        bus.im_gnt = 1'b0; bus.id_ready = 1'b0; bus.redir = 1'b0; bus.redir_pc = '0;
        bus.im_rvalid = 1'b0; bus.im_rdata = '0;
        bus8.im_gnt = 1'b0; bus8.id_ready = 1'b0; bus8.redir = 1'b0; bus8.redir_pc = '0;
        bus8.im_rvalid = 1'b0; bus8.im_rdata = '0;
        mq.delete();
        qm.delete();
        epoch = 0;
        fetch_exp = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    // One clock cycle: drive inputs, sample and check at negedge, advance the model.
    task automatic cycle();
        logic ex_req, ex_valid;
        req_t r;
        ent_t e;
        bus.im_gnt   = c_gnt;
        bus.id_ready = c_ready;
        bus.redir    = c_redir;
        bus.redir_pc = c_rpc;
        cur_rv    = (mq.size() > 0) && (mq[0].rdy <= cyc);
        cur_rdata = $urandom();
        bus.im_rvalid = cur_rv;
        bus.im_rdata  = cur_rdata;
        bus8.im_gnt    = 1'b1;
        bus8.id_ready  = 1'b1;
        bus8.redir     = c_redir8;
        bus8.redir_pc  = c_rpc8;
        bus8.im_rvalid = nxt8;
        bus8.im_rdata  = $urandom();
        @(negedge clk);
        s_req = bus.im_req;  s_addr = bus.im_addr;  s_valid = bus.id_valid;
        s_pc4 = bus.id_pc4;  s_instr = bus.id_instr;
        s8_req = bus8.im_req; s8_addr = bus8.im_addr; s8_valid = bus8.id_valid;
        s8_pc4 = bus8.id_pc4;
        nxt8 = bus8.im_req;
        ex_req   = !c_redir && ((qm.size() + mq.size()) < DEPTH);
        ex_valid = (qm.size() != 0);
        check("im_req", s_req, ex_req);
        check("fetch_pc", bus.fetch_pc, fetch_exp);
        if (ex_req) check("im_addr", s_addr, fetch_exp);
        check("id_valid", s_valid, ex_valid);
        if (ex_valid) begin
            check("id_pc4", s_pc4, qm[0].pc + 32'd4);
            check("id_instr", s_instr, qm[0].instr);
        end
        r = '{addr: '0, epoch: 0, rdy: 0};
        if (cur_rv) r = mq.pop_front();
        if (c_redir) begin
            qm.delete();
            epoch++;
            fetch_exp = c_rpc & ~32'h3;
        end else begin
            if (ex_valid && c_ready) begin
                qm.delete(0);
                n_consumed++;
            end
            if (cur_rv && r.epoch == epoch) begin
                e.pc = r.addr;
                e.instr = cur_rdata;
                qm.push_back(e);
            end
            if (ex_req && c_gnt) begin
                r.addr = fetch_exp; r.epoch = epoch; r.rdy = cyc + c_lat;
                mq.push_back(r);
                fetch_exp = fetch_exp + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int grants;
        int found;
        n_chk = 0; n_fail = 0; n_consumed = 0; cyc = 0;

        // Startup stream: grant always, one-cycle latency, decode always ready.
        tbl[0] = '{1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd4};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd8};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd12};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd16};

        do_reset();
        check("reset_req", bus.im_req, 1'b1);
        check("reset_valid", bus.id_valid, 1'b0);
        check("reset_instr", bus.id_instr, 32'h0);
        check("reset_pc4", bus.id_pc4, 32'h0);
        check("reset_addr", bus.im_addr, 32'h0);
        c_lat = 1;
        for (int i = 0; i < 6; i++) begin
            c_gnt = tbl[i].gnt;
            c_ready = tbl[i].ready;
            cycle();
            check("t1_req", s_req, tbl[i].exp_req);
            check("t1_addr", s_addr, tbl[i].exp_addr);
            check("t1_valid", s_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) check("t1_pc4", s_pc4, tbl[i].exp_pc4);
        end

        // Decode stalled: credits run out after DEPTH grants, then drain.
        do_reset();
        c_gnt = 1'b1; c_ready = 1'b0; c_lat = 1;
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_req && c_gnt) grants++;
        end
        check("t2_grants", grants, DEPTH);
        check("t2_req_stall", s_req, 1'b0);
        c_ready = 1'b1;
        cycle();
        check("t2_head0", s_pc4, 32'd4);
        check("t2_req_full", s_req, 1'b0);
        cycle();
        check("t2_head1", s_pc4, 32'd8);
        check("t2_req_resume", s_req, 1'b1);
        check("t2_addr_resume", s_addr, 32'd16);

        // Redirect with three responses in flight (latency 4).
        do_reset();
        c_gnt = 1'b1; c_ready = 1'b1; c_lat = 4;
        repeat (3) cycle();
        c_redir = 1'b1; c_rpc = 32'h43;
        cycle();
        check("t3_req_redir", s_req, 1'b0);
        c_redir = 1'b0;
        cycle();
        check("t3_req_after", s_req, 1'b1);
        check("t3_addr_after", s_addr, 32'h40);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            cycle();
            if (s_valid) begin
                found = 1;
                check("t3_first_pc4", s_pc4, 32'h44);
            end
        end
        check("t3_seen", found, 1);

        // Redirect coincident with a response and a pop.
        do_reset();
        c_gnt = 1'b1; c_ready = 1'b1; c_lat = 2;
        repeat (3) cycle();
        c_redir = 1'b1; c_rpc = 32'h200;
        cycle();
        check("t4_rvalid", cur_rv, 1'b1);
        check("t4_req_redir", s_req, 1'b0);
        check("t4_valid_redir", s_valid, 1'b1);
        c_redir = 1'b0;
        cycle();
        check("t4_valid_flushed", s_valid, 1'b0);
        check("t4_req_after", s_req, 1'b1);
        check("t4_addr_after", s_addr, 32'h200);
        cycle();
        check("t4_dropped_c5", s_valid, 1'b0);
        cycle();
        check("t4_dropped_c6", s_valid, 1'b0);
        cycle();
        check("t4_valid_new", s_valid, 1'b1);
        check("t4_pc4_new", s_pc4, 32'h204);

        // 8-bit PC wrap on the narrow instance.
        do_reset();
        c_redir8 = 1'b1; c_rpc8 = 8'hFC;
        cycle();
        check("t5_req_redir", s8_req, 1'b0);
        c_redir8 = 1'b0;
        cycle();
        check("t5_addr0", s8_addr, 8'hFC);
        cycle();
        check("t5_addr1", s8_addr, 8'h00);
        cycle();
        check("t5_addr2", s8_addr, 8'h04);
        check("t5_valid", s8_valid, 1'b1);
        check("t5_pc4_0", s8_pc4, 8'h00);
        cycle();
        check("t5_pc4_1", s8_pc4, 8'h04);
        cycle();
        check("t5_pc4_2", s8_pc4, 8'h08);

        // Asynchronous reset between clock edges during a burst.
        do_reset();
        c_gnt = 1'b1; c_ready = 1'b1; c_lat = 1;
        repeat (5) cycle();
        #2;
        rst = 1'b1;
        #1;
        check("t6_req_async", bus.im_req, 1'b0);
        check("t6_valid_async", bus.id_valid, 1'b0);
        do_reset();
        c_gnt = 1'b1; c_ready = 1'b1; c_lat = 1;
        cycle();
        check("t6_req_first", s_req, 1'b1);
        check("t6_addr_first", s_addr, 32'h0);

        // Randomized traffic against the model.
        do_reset();
        n_consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            c_gnt   = ($urandom_range(3) != 0);
            c_ready = ($urandom_range(9) < 7);
            c_redir = ($urandom_range(19) == 0);
            c_rpc   = $urandom();
            c_lat   = $urandom_range(4, 1);
            cycle();
        end
        c_redir = 1'b0; c_gnt = 1'b0; c_ready = 1'b1; c_lat = 1;
        repeat (20) cycle();
        check("rand_consumed", (n_consumed > 200) ? 1 : 0, 1);
        check("rand_drained", s_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
